// File: rtl/ex_stage_if.sv
// ID/EX-to-execute bundle: instruction fields from the ID/EX register and the
// registered writeback fields plus the combinational stall back to upstream.
interface ex_stage_if #(
    parameter int DATA_W = 32
);
    logic              wb_in;
    logic [1:0]        ALU_OP_in;
    logic [DATA_W-1:0] src_data_in;
    logic [DATA_W-1:0] tar_data_in;
    logic [4:0]        shamt_in;
    logic [4:0]        dst_addr_in;
    logic [5:0]        funct_ctrl_in;
    logic              stall_out;
    logic              wb_out;
    logic [4:0]        dst_addr_out;
    logic [DATA_W-1:0] result_out;

    modport master (
        output wb_in, ALU_OP_in, src_data_in, tar_data_in, shamt_in,
               dst_addr_in, funct_ctrl_in,
        input  stall_out, wb_out, dst_addr_out, result_out
    );

    modport slave (
        input  wb_in, ALU_OP_in, src_data_in, tar_data_in, shamt_in,
               dst_addr_in, funct_ctrl_in,
        output stall_out, wb_out, dst_addr_out, result_out
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-iteration shift-add MULTU writing HI/LO.
// All state advances on the falling edge of clk.
module ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_if.slave ex
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                           F_SLT = 6'h2A, F_SLL = 6'h00, F_SRL = 6'h02, F_MULTU = 6'h19,
                           F_MFHI = 6'h10, F_MFLO = 6'h12;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d, addend, product;
    logic [DATA_W-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, res_q, res_d, alu_res;
    logic [4:0]          dst_q, dst_d;
    logic                wb_q, wb_d, done_q, done_d;
    logic                alu_ok, is_multu, issue;
    logic signed [DATA_W-1:0] src_s, tar_s;

    assign src_s    = ex.src_data_in;
    assign tar_s    = ex.tar_data_in;
    assign is_multu = (ex.ALU_OP_in == 2'b10) && (ex.funct_ctrl_in == F_MULTU);

    always_ff @(negedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = MUL;
            MUL:     if (cnt_q == LAST_CNT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done_q marks the cycle right after completion, where the still-held MULTU must not re-issue.
    always_comb begin
        issue        = (state_q == IDLE) && is_multu && !done_q;
        ex.stall_out = (state_q == MUL) || issue;
    end

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (ex.ALU_OP_in)
            2'b00: alu_res = ex.src_data_in + ex.tar_data_in;
            2'b01: alu_res = ex.src_data_in - ex.tar_data_in;
            2'b10: begin
                case (ex.funct_ctrl_in)
                    F_ADD:   alu_res = ex.src_data_in + ex.tar_data_in;
                    F_SUB:   alu_res = ex.src_data_in - ex.tar_data_in;
                    F_AND:   alu_res = ex.src_data_in & ex.tar_data_in;
                    F_OR:    alu_res = ex.src_data_in | ex.tar_data_in;
                    F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, (src_s < tar_s)};
                    F_SLL:   alu_res = ex.tar_data_in << ex.shamt_in;
                    F_SRL:   alu_res = ex.tar_data_in >> ex.shamt_in;
                    F_MFHI:  alu_res = hi_q;
                    F_MFLO:  alu_res = lo_q;
                    default: alu_ok  = 1'b0;
                endcase
            end
            default: alu_ok = 1'b0;
        endcase
    end

    // Multiplier bit i adds the multiplicand shifted by i into the accumulator.
    assign addend  = mplier_q[0] ? ({{DATA_W{1'b0}}, mcand_q} << cnt_q) : '0;
    assign product = acc_q + addend;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        wb_d     = 1'b0;
        dst_d    = '0;
        res_d    = '0;
        if (state_q == IDLE) begin
            if (issue) begin
                mcand_d  = ex.src_data_in;
                mplier_d = ex.tar_data_in;
                acc_d    = '0;
                cnt_d    = '0;
            end else if (alu_ok) begin
                res_d = alu_res;
                dst_d = ex.dst_addr_in;
                wb_d  = ex.wb_in && (ex.dst_addr_in != 5'd0);
            end
        end else begin
            acc_d    = product;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
                {hi_d, lo_d} = product;
                done_d       = 1'b1;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            wb_q     <= 1'b0;
            dst_q    <= '0;
            res_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            wb_q     <= wb_d;
            dst_q    <= dst_d;
            res_q    <= res_d;
        end
    end

    assign ex.wb_out       = wb_q;
    assign ex.dst_addr_out = dst_q;
    assign ex.result_out   = res_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases plus random instruction stream against a
// behavioural model (plain arithmetic, multiply modelled as a 32-edge busy countdown).
module tb_ex_stage;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                           F_SLT = 6'h2A, F_SLL = 6'h00, F_SRL = 6'h02, F_MULTU = 6'h19,
                           F_MFHI = 6'h10, F_MFLO = 6'h12;

    logic clk = 1'b1;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    ex_stage_if #(.DATA_W(32)) ex_if ();
    ex_stage #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .ex(ex_if));

    always #5 clk = ~clk;

    // Model state
    logic        m_wb, m_hi_dummy;
    logic [4:0]  m_dst;
    logic [31:0] m_res, m_hi, m_lo;
    logic [63:0] m_prod;
    int          m_busy;
    bit          m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_multu();
        return (ex_if.ALU_OP_in == 2'b10) && (ex_if.funct_ctrl_in == F_MULTU);
    endfunction

    always @(negedge clk) begin
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] s, t;
        logic [4:0]  sh, d;
        bit          ok, prev_done;
        op = ex_if.ALU_OP_in; f = ex_if.funct_ctrl_in;
        s = ex_if.src_data_in; t = ex_if.tar_data_in;
        sh = ex_if.shamt_in; d = ex_if.dst_addr_in;
        if (!rst_n) begin
            m_wb = 0; m_dst = 0; m_res = 0; m_hi = 0; m_lo = 0;
            m_busy = 0; m_done = 0;
        end else if (m_busy > 0) begin
            m_wb = 0; m_dst = 0; m_res = 0; m_done = 0;
            m_busy--;
            if (m_busy == 0) begin
                {m_hi, m_lo} = m_prod;
                m_done = 1;
            end
        end else begin
            prev_done = m_done;
            m_done = 0;
            ok = 1;
            m_res = 0;
            case (op)
                2'b00: m_res = s + t;
                2'b01: m_res = s - t;
                2'b10: case (f)
                    F_ADD:  m_res = s + t;
                    F_SUB:  m_res = s - t;
                    F_AND:  m_res = s & t;
                    F_OR:   m_res = s | t;
                    F_SLT:  m_res = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
                    F_SLL:  m_res = t << sh;
                    F_SRL:  m_res = t >> sh;
                    F_MFHI: m_res = m_hi;
                    F_MFLO: m_res = m_lo;
                    F_MULTU: begin
                        ok = 0;
                        if (!prev_done) begin
                            m_prod = {32'd0, s} * {32'd0, t};
                            m_busy = 32;
                        end
                    end
                    default: ok = 0;
                endcase
                default: ok = 0;
            endcase
            if (!ok) m_res = 0;
            m_dst = ok ? d : 5'd0;
            m_wb  = ok && ex_if.wb_in && (d != 0);
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            check("wb_out", {31'd0, ex_if.wb_out}, {31'd0, m_wb});
            check("dst_addr_out", {27'd0, ex_if.dst_addr_out}, {27'd0, m_dst});
            check("result_out", ex_if.result_out, m_res);
            check("stall_out", {31'd0, ex_if.stall_out},
                  {31'd0, (m_busy > 0) || (in_multu() && !m_done)});
        end
    end

    task automatic present(input logic [1:0] op, input logic [5:0] f, input logic [31:0] s,
                           input logic [31:0] t, input logic [4:0] sh, input logic [4:0] d,
                           input logic w);
        ex_if.ALU_OP_in = op; ex_if.funct_ctrl_in = f;
        ex_if.src_data_in = s; ex_if.tar_data_in = t;
        ex_if.shamt_in = sh; ex_if.dst_addr_in = d; ex_if.wb_in = w;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Upstream behaviour: hold the presented instruction while stall_out is high.
    task automatic issue(output int stalls);
        bit s;
        bit released;
        stalls = 0;
        released = 0;
        #1;
        for (int k = 0; k < 100 && !released; k++) begin
            s = ex_if.stall_out;
            step();
            if (s) stalls++;
            if (!ex_if.stall_out) released = 1;
        end
        if (!released) check("stall_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input logic [1:0] op, input logic [5:0] f, input logic [31:0] s,
                       input logic [31:0] t, input logic [4:0] sh, input logic [4:0] d,
                       input logic w, output int stalls);
        present(op, f, s, t, sh, d, w);
        issue(stalls);
    endtask

    initial begin
        int n;
        int r;
        bit prev_mul;
        logic [5:0] flist [10];
        logic [31:0] a, b;
        flist = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_MULTU, F_MFHI, F_MFLO};
        rst_n = 0;
        present(2'b11, 6'h00, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk_en = 1;
        step();
        check("rst_result", ex_if.result_out, 32'd0);
        check("rst_wb", {31'd0, ex_if.wb_out}, 32'd0);
        check("rst_stall", {31'd0, ex_if.stall_out}, 32'd0);
        rst_n = 1;

        run(2'b10, F_ADD, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd5, 1'b1, n);
        check("add_wrap_res", ex_if.result_out, 32'h80000000);
        check("add_wrap_dst", {27'd0, ex_if.dst_addr_out}, 32'd5);
        check("add_wrap_wb", {31'd0, ex_if.wb_out}, 32'd1);
        run(2'b10, F_SLT, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd7, 1'b1, n);
        check("slt_neg", ex_if.result_out, 32'd1);
        run(2'b10, F_SRL, 32'd0, 32'h80000000, 5'd31, 5'd7, 1'b1, n);
        check("srl_31", ex_if.result_out, 32'd1);
        run(2'b10, F_ADD, 32'd1, 32'd2, 5'd0, 5'd0, 1'b1, n);
        check("dst0_wb", {31'd0, ex_if.wb_out}, 32'd0);
        run(2'b10, 6'h3F, 32'd9, 32'd9, 5'd0, 5'd4, 1'b1, n);
        check("bad_funct_res", ex_if.result_out, 32'd0);
        check("bad_funct_wb", {31'd0, ex_if.wb_out}, 32'd0);

        run(2'b10, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, n);
        check("multu_stall_edges", n, 32'd33);
        run(2'b10, F_MFHI, 32'd0, 32'd0, 5'd0, 5'd2, 1'b1, n);
        check("mfhi_max", ex_if.result_out, 32'hFFFFFFFE);
        run(2'b10, F_MFLO, 32'd0, 32'd0, 5'd0, 5'd3, 1'b1, n);
        check("mflo_max", ex_if.result_out, 32'h00000001);

        run(2'b10, F_MULTU, 32'd2, 32'd3, 5'd0, 5'd0, 1'b0, n);
        run(2'b10, F_MFLO, 32'd0, 32'd0, 5'd0, 5'd3, 1'b1, n);
        check("b2b_mflo", ex_if.result_out, 32'd6);
        check("b2b_mflo_wb", {31'd0, ex_if.wb_out}, 32'd1);

        present(2'b10, F_MULTU, 32'd3, 32'd5, 5'd0, 5'd0, 1'b0);
        #1;
        repeat (11) step();
        rst_n = 0;
        present(2'b10, F_MFLO, 32'd0, 32'd0, 5'd0, 5'd3, 1'b1);
        step();
        rst_n = 1;
        check("stall_after_rst", {31'd0, ex_if.stall_out}, 32'd0);
        run(2'b10, F_MFLO, 32'd0, 32'd0, 5'd0, 5'd3, 1'b1, n);
        check("mflo_after_abort", ex_if.result_out, 32'd0);
        run(2'b10, F_MFHI, 32'd0, 32'd0, 5'd0, 5'd3, 1'b1, n);
        check("mfhi_after_abort", ex_if.result_out, 32'd0);

        prev_mul = 1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            if (r < 2) begin
                rst_n = 0;
                step();
                rst_n = 1;
                prev_mul = 0;
            end else if (r < 10 && !prev_mul) begin
                run(2'b10, F_MULTU, a, b, 5'($urandom), 5'($urandom), 1'($urandom), n);
                prev_mul = 1;
            end else begin
                if (r < 16)      present(2'b00, 6'($urandom), a, b, 5'($urandom), 5'($urandom), 1'($urandom));
                else if (r < 22) present(2'b01, 6'($urandom), a, b, 5'($urandom), 5'($urandom), 1'($urandom));
                else if (r < 26) present(2'b11, 6'($urandom), a, b, 5'($urandom), 5'($urandom), 1'($urandom));
                else if (r < 32) present(2'b10, 6'($urandom), a, b, 5'($urandom), 5'($urandom), 1'($urandom));
                else begin
                    present(2'b10, flist[$urandom_range(0, 9)], a, b, 5'($urandom),
                            5'($urandom), 1'($urandom));
                    if (prev_mul && in_multu()) ex_if.funct_ctrl_in = F_MFLO;
                end
                prev_mul = in_multu();
                issue(n);
            end
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  clock; all state updates on the falling edge of clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 wb_in  input  1  register-write enable from the ID/EX register.
REQ-005 ALU_OP_in  input  2  ALU operation class: 00 add, 01 sub, 10 R-type by funct, 11 reserved.
REQ-006 src_data_in  input  32  rs operand.
REQ-007 tar_data_in  input  32  rt operand.
REQ-008 shamt_in  input  5  shift amount.
REQ-009 dst_addr_in  input  5  destination register number.
REQ-010 funct_ctrl_in  input  6  R-type funct field.
REQ-011 stall_out  output  1  high while the multiplier is busy; upstream holds its ID/EX inputs while high.
REQ-012 wb_out  output  1  registered write enable to writeback.
REQ-013 dst_addr_out  output  5  registered destination register number.
REQ-014 result_out  output  32  registered ALU result.

Function
REQ-015 Decode with ALU_OP 10: funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL, 0x19 MULTU, 0x10 MFHI, 0x12 MFLO.
REQ-016 Any other funct, or ALU_OP 11, gives result 0 with wb_out 0.
REQ-017 ADD/SUB and ALU_OP 00/01 wrap modulo 2^32; no overflow flag or exception.
REQ-018 SLT is a signed compare giving 1 or 0; SLL/SRL shift tar_data by shamt, zero-filling.
REQ-019 MFHI/MFLO return the internal 32-bit HI/LO registers.
REQ-020 Single-cycle ops: result_out, dst_addr_out and wb_out update at the falling edge that samples the inputs (latency 1 edge).
REQ-021 wb_out = wb_in AND (dst_addr_in != 0).
REQ-022 FSM states: IDLE and MUL.
REQ-023 IDLE + MULTU: latch both operands, clear the 64-bit accumulator, counter=0, go to MUL.
REQ-024 MULTU itself registers a bubble (wb_out 0, result_out 0, dst_addr_out 0).
REQ-025 stall_out is combinational: high in MUL, and high in IDLE while MULTU is presented, so upstream holds.
REQ-026 MUL: one shift-add iteration per edge (unsigned, 1 multiplier bit per cycle); counter increments 0..31.
REQ-027 MUL: result stage registers a bubble every edge; inputs are ignored.
REQ-028 On the edge where counter==31: write {HI,LO} = 64-bit product, return to IDLE; stall_out drops after that edge.
REQ-029 MULTU total stall is 33 edges including the issue edge.
REQ-030 The held MULTU is not re-issued on the edge after completion; the upstream instruction following it is issued in that same cycle.
REQ-031 An instruction following MULTU (including MFHI/MFLO) sees the updated HI/LO; no hazard.

Reset
REQ-032 rst_n low at a falling edge: wb_out=0, dst_addr_out=0, result_out=0, HI=LO=0, FSM=IDLE, counter=0, accumulator=0.
REQ-033 Reset has priority over all activity; asserting it mid-multiply aborts the MULTU and leaves HI/LO=0.
REQ-034 stall_out is 0 the cycle after reset, unless MULTU is presented.

Verification
REQ-035 ADD, src=0x7FFFFFFF, tar=1, dst=5, wb=1 -> one edge later result_out=0x80000000, dst_addr_out=5, wb_out=1.
REQ-036 SLT, src=0xFFFFFFFF, tar=0 -> result_out=1; SRL, tar=0x80000000, shamt=31 -> result_out=1.
REQ-037 wb_in=1, dst=0, ADD -> wb_out=0; unknown funct 0x3F -> result_out=0, wb_out=0.
REQ-038 MULTU, 0xFFFFFFFF x 0xFFFFFFFF, then MFHI and MFLO -> stall_out high 33 edges; MFHI=0xFFFFFFFE; MFLO=0x00000001; bubbles (wb_out 0) during stall.
REQ-039 MULTU 3x5, rst_n low at iteration 10, then MFLO -> stall_out 0 after reset, MFLO=0, FSM IDLE.
REQ-040 Back-to-back: MULTU 2x3 then immediately MFLO -> MFLO result_out=6 on the first edge after stall_out falls.
